// File: rtl/drisc_bus_pkg.sv
// Shared encodings and helpers for the drisc external memory bus responder.
package drisc_bus_pkg;

    // Transfer size as driven on data_size by the core.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    // Register offsets inside the 16-byte I/O window.
    localparam logic [3:0] IO_GPIO  = 4'h0;
    localparam logic [3:0] IO_COUNT = 4'h4;
    localparam logic [3:0] IO_ERR   = 4'h8;

    // Byte-lane enables for a transfer of the given size at the given lane offset.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = 4'b0011 << off;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/drisc_byte_lane_decode.sv
// Byte-lane decode: turns size/offset into lane enables and an alignment-legal flag.
module drisc_byte_lane_decode
    import drisc_bus_pkg::*;
(
    input  logic [1:0] data_size,
    input  logic [1:0] offset,
    output logic [3:0] byte_en,
    output logic       align_ok
);

    // Lane enables plus natural-alignment check; the reserved size is never legal.
    always_comb begin
        byte_en  = byte_enable(data_size, offset);
        align_ok = 1'b0;
        case (data_size)
            SIZE_BYTE: align_ok = 1'b1;
            SIZE_HALF: align_ok = (offset[0] == 1'b0);
            SIZE_WORD: align_ok = (offset == 2'b00);
            default:   align_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/drisc_bus_responder.sv
// Target end of the drisc external memory bus: word RAM plus a small I/O window
// (GPIO, free-running cycle counter, last error address). Fixed one-edge latency.
module drisc_bus_responder
    import drisc_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter string       MEM_INIT   = "",
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_bus,
    input  logic [31:0] data_bus_out,
    input  logic        data_bus_out_enable,
    input  logic [1:0]  data_size,
    input  logic        write_address,
    input  logic        write,
    input  logic        read,
    output logic [31:0] data_bus_in,
    output logic [31:0] gpio_out,
    output logic        bus_error
);

    localparam int          RAM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [32:0] RAM_LIMIT = 33'd4 << ADDR_WIDTH;
    localparam logic [32:0] IO_LO     = {1'b0, IO_BASE};
    localparam logic [32:0] IO_HI     = IO_LO + 33'd16;
    localparam logic [3:0]  IO_BASE_LO = IO_BASE[3:0];

    // Contents are undefined unless a simulation/FPGA flow preloads them from MEM_INIT.
    logic [31:0] ram_r [RAM_WORDS];

    logic [31:0] latched_addr_r;
    logic [31:0] data_bus_in_r;
    logic [31:0] gpio_r;
    logic [31:0] cycle_count_r;
    logic [31:0] err_addr_r;
    logic        bus_error_r;

    logic [31:0]           acc_addr_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [3:0]            byte_en_s;
    logic                  align_ok_s;
    logic                  ram_hit_s;
    logic                  io_hit_s;
    logic [3:0]            io_off_s;
    logic                  legal_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic                  rd_bad_s;
    logic                  err_s;
    logic                  ram_we_s;
    logic                  gpio_we_s;
    logic [31:0]           rd_data_s;

    assign acc_addr_s = (write_address && (read || write)) ? address_bus : latched_addr_r;
    assign word_idx_s = acc_addr_s[ADDR_WIDTH+1:2];

    drisc_byte_lane_decode u_lane_decode (
        .data_size (data_size),
        .offset    (acc_addr_s[1:0]),
        .byte_en   (byte_en_s),
        .align_ok  (align_ok_s)
    );

    // Address map, legality and strobe qualification for the current access.
    always_comb begin
        ram_hit_s = ({1'b0, acc_addr_s} < RAM_LIMIT);
        io_hit_s  = ({1'b0, acc_addr_s} >= IO_LO) && ({1'b0, acc_addr_s} < IO_HI);
        io_off_s  = acc_addr_s[3:0] - IO_BASE_LO;
        legal_s   = align_ok_s && (ram_hit_s || (io_hit_s && (data_size == SIZE_WORD)));
        wr_ok_s   = write && legal_s && data_bus_out_enable;
        rd_ok_s   = read && !write && legal_s;
        rd_bad_s  = read && !write && !legal_s;
        // Read+write together always flags an error even when the write itself lands.
        err_s     = (write && !(legal_s && data_bus_out_enable)) || rd_bad_s || (read && write);
        ram_we_s  = wr_ok_s && ram_hit_s;
        gpio_we_s = wr_ok_s && io_hit_s && (io_off_s == IO_GPIO);
    end

    // Read data mux; counter and error register return their pre-edge values.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (ram_hit_s) begin
            rd_data_s = ram_r[word_idx_s];
        end else begin
            case (io_off_s)
                IO_GPIO:  rd_data_s = gpio_r;
                IO_COUNT: rd_data_s = cycle_count_r;
                IO_ERR:   rd_data_s = err_addr_r;
                default:  rd_data_s = 32'h0000_0000;
            endcase
        end
    end

    // RAM byte-lane write port; suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset && ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    ram_r[word_idx_s][8*i +: 8] <= data_bus_out[8*i +: 8];
                end
            end
        end
    end

    // Control/status registers, read data register and error pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            latched_addr_r <= 32'h0000_0000;
            data_bus_in_r  <= 32'h0000_0000;
            gpio_r         <= 32'h0000_0000;
            cycle_count_r  <= 32'h0000_0000;
            err_addr_r     <= 32'h0000_0000;
            bus_error_r    <= 1'b0;
        end else begin
            cycle_count_r <= cycle_count_r + 32'd1;
            bus_error_r   <= err_s;
            if (write_address) begin
                latched_addr_r <= address_bus;
            end
            if (err_s) begin
                err_addr_r <= acc_addr_s;
            end
            if (gpio_we_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en_s[i]) begin
                        gpio_r[8*i +: 8] <= data_bus_out[8*i +: 8];
                    end
                end
            end
            if (rd_ok_s) begin
                data_bus_in_r <= rd_data_s;
            end else if (rd_bad_s) begin
                data_bus_in_r <= 32'h0000_0000;
            end
        end
    end

    assign data_bus_in = data_bus_in_r;
    assign gpio_out    = gpio_r;
    assign bus_error   = bus_error_r;

endmodule

// File: tb/tb_drisc_bus_responder.sv
// Directed self-checking bench for drisc_bus_responder.
module tb_drisc_bus_responder;

    localparam logic [31:0] IOB = 32'hFFFF_FF00;

    logic        clock;
    logic        reset;
    logic [31:0] address_bus;
    logic [31:0] data_bus_out;
    logic        data_bus_out_enable;
    logic [1:0]  data_size;
    logic        write_address;
    logic        write;
    logic        read;
    logic [31:0] data_bus_in;
    logic [31:0] gpio_out;
    logic        bus_error;

    int tests;
    int fails;
    logic [31:0] c1;
    logic [31:0] c2;

    drisc_bus_responder #(.ADDR_WIDTH(10), .MEM_INIT(""), .IO_BASE(IOB)) dut (
        .clock               (clock),
        .reset               (reset),
        .address_bus         (address_bus),
        .data_bus_out        (data_bus_out),
        .data_bus_out_enable (data_bus_out_enable),
        .data_size           (data_size),
        .write_address       (write_address),
        .write               (write),
        .read                (read),
        .data_bus_in         (data_bus_in),
        .gpio_out            (gpio_out),
        .bus_error           (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bypassed access over one edge, then strobes drop.
    task automatic acc(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] d, input logic [1:0] sz, input logic oe);
        write_address       = 1'b1;
        address_bus         = a;
        read                = rd;
        write               = wr;
        data_bus_out        = d;
        data_size           = sz;
        data_bus_out_enable = oe;
        tick();
        write_address       = 1'b0;
        read                = 1'b0;
        write               = 1'b0;
        data_bus_out_enable = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        address_bus = 32'h0;
        data_bus_out = 32'h0;
        data_bus_out_enable = 1'b0;
        data_size = 2'd2;
        write_address = 1'b0;
        write = 1'b0;
        read = 1'b0;
        tick();
        tick();
        chk("rst_data", data_bus_in, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_err", {31'd0, bus_error}, 32'h0);
        reset = 1'b1;

        // Latch, then write and read through the latched address.
        write_address = 1'b1; address_bus = 32'h100; tick();
        write_address = 1'b0; address_bus = 32'h300;
        write = 1'b1; data_bus_out = 32'hDEAD_BEEF; data_size = 2'd2; data_bus_out_enable = 1'b1;
        tick();
        chk("latched_wr_err", {31'd0, bus_error}, 32'h0);
        write = 1'b0; data_bus_out_enable = 1'b0; read = 1'b1; tick();
        read = 1'b0;
        chk("latched_rd", data_bus_in, 32'hDEAD_BEEF);
        chk("latched_rd_err", {31'd0, bus_error}, 32'h0);
        tick();
        chk("rd_hold", data_bus_in, 32'hDEAD_BEEF);

        // Byte and half lane writes.
        acc(32'h100, 1'b0, 1'b1, 32'h1122_3344, 2'd2, 1'b1);
        acc(32'h101, 1'b0, 1'b1, 32'h0000_AA00, 2'd0, 1'b1);
        acc(32'h100, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("byte_wr", data_bus_in, 32'h1122_AA44);
        acc(32'h102, 1'b0, 1'b1, 32'h5566_0000, 2'd1, 1'b1);
        acc(32'h100, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("half_wr", data_bus_in, 32'h5566_AA44);

        // Misaligned accesses.
        acc(32'h103, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'd1, 1'b1);
        chk("mis_half_err", {31'd0, bus_error}, 32'h1);
        tick();
        chk("err_one_cycle", {31'd0, bus_error}, 32'h0);
        acc(32'h102, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("mis_word_err", {31'd0, bus_error}, 32'h1);
        chk("mis_rd_zero", data_bus_in, 32'h0);
        acc(32'h100, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("mis_no_change", data_bus_in, 32'h5566_AA44);
        acc(IOB + 32'h8, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("err_addr", data_bus_in, 32'h0000_0102);

        // I/O window.
        acc(IOB, 1'b0, 1'b1, 32'h0000_000F, 2'd2, 1'b1);
        chk("gpio_wr", gpio_out, 32'h0000_000F);
        chk("gpio_wr_err", {31'd0, bus_error}, 32'h0);
        acc(IOB + 32'h4, 1'b0, 1'b1, 32'h0000_1234, 2'd2, 1'b1);
        chk("cnt_wr_noerr", {31'd0, bus_error}, 32'h0);
        acc(IOB + 32'h4, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        c1 = data_bus_in;
        tick(); tick(); tick(); tick();
        acc(IOB + 32'h4, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        c2 = data_bus_in;
        chk("cnt_delta", c2 - c1, 32'd5);
        acc(IOB, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        chk("io_byte_err", {31'd0, bus_error}, 32'h1);
        acc(32'h0000_1000, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("unmapped_err", {31'd0, bus_error}, 32'h1);
        acc(32'h0000_0FFC, 1'b0, 1'b1, 32'hA5A5_0FFC, 2'd2, 1'b1);
        acc(32'h0000_0FFC, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("ram_top", data_bus_in, 32'hA5A5_0FFC);
        chk("ram_top_err", {31'd0, bus_error}, 32'h0);

        // Simultaneous read+write, and write without data enable.
        acc(32'h200, 1'b0, 1'b1, 32'hAAAA_AAAA, 2'd2, 1'b1);
        acc(32'h200, 1'b1, 1'b1, 32'h1234_5678, 2'd2, 1'b1);
        chk("rdwr_err", {31'd0, bus_error}, 32'h1);
        chk("rdwr_hold", data_bus_in, 32'hA5A5_0FFC);
        acc(32'h200, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("rdwr_ram", data_bus_in, 32'h1234_5678);
        acc(32'h200, 1'b0, 1'b1, 32'h0BAD_0BAD, 2'd2, 1'b0);
        chk("no_oe_err", {31'd0, bus_error}, 32'h1);
        acc(32'h200, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("no_oe_keep", data_bus_in, 32'h1234_5678);

        // Reset during a write.
        acc(IOB, 1'b0, 1'b1, 32'h0000_00FF, 2'd2, 1'b1);
        chk("gpio_ff", gpio_out, 32'h0000_00FF);
        reset = 1'b0;
        acc(32'h200, 1'b0, 1'b1, 32'hCAFE_F00D, 2'd2, 1'b1);
        chk("rst2_gpio", gpio_out, 32'h0);
        chk("rst2_err", {31'd0, bus_error}, 32'h0);
        chk("rst2_data", data_bus_in, 32'h0);
        reset = 1'b1;
        acc(IOB + 32'h4, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("rst2_cnt", data_bus_in, 32'h0);
        acc(32'h200, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0);
        chk("rst2_no_commit", data_bus_in, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/drisc_bus_responder.md
Name: drisc_bus_responder

Overview:
- Target end of the drisc external memory bus. Latches the address, serves reads and writes with fixed latency, and applies byte-lane write enables.
- Backs a word-organised RAM plus a small memory-mapped I/O window: a GPIO output register, a free-running cycle counter and an error-address register.
- Sits outside the core and connects directly to the core's address/data/strobe pads. There is no ready/wait handshake, so latency is fixed.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width (2^10 words = 4 KiB, byte addresses 0x000-0xFFF).
- MEM_INIT, "", hex file loaded into RAM at elaboration; empty means RAM contents are undefined.
- IO_BASE, 32'hFFFF_FF00, byte base of the I/O window (16 bytes).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- address_bus  in  32  byte address from the core.
- data_bus_out  in  32  write data from the core, lane-positioned (byte n of the word on bits 8n+7:8n).
- data_bus_out_enable  in  1  core is driving data_bus_out.
- data_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- write_address  in  1  latch address_bus this cycle.
- write  in  1  write strobe.
- read  in  1  read strobe.
- data_bus_in  out  32  read data to the core (full aligned word).
- gpio_out  out  32  GPIO register contents.
- bus_error  out  1  one-cycle pulse on an illegal access.

Behaviour:
- Reset (reset==0 at a rising edge):
  - latched_addr, data_bus_in, gpio_out, cycle_count and err_addr all go to 0; bus_error goes to 0.
  - RAM is not cleared.
  - Any access in flight is dropped.
- Address latch: on an edge with write_address=1, latched_addr <= address_bus.
  - If read or write is also asserted in that cycle, the access uses address_bus directly (bypass).
  - Otherwise the access uses latched_addr.
- Access address = bypass ? address_bus : latched_addr. Lane offset = addr[1:0]; word index = addr[ADDR_WIDTH+1:2].
- Legality: size 3 is illegal.
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - A RAM access is in range when addr < 4*2^ADDR_WIDTH.
  - An I/O access is in range when IO_BASE <= addr < IO_BASE+16, and I/O accesses must be word-sized.
  - Any other address is unmapped, which is an error.
- Read latency is 1. With read=1 at edge N, data_bus_in holds the full aligned word from edge N onward and stays held until the next read. Lane extraction and sign extension belong to the core.
- Illegal read: data_bus_in <= 0.
- Write is committed at the edge where write=1.
  - Byte enables: byte -> 1 << off; half -> 2'b11 << off; word -> 4'hF.
  - Only enabled lanes of RAM or GPIO change.
  - A write with data_bus_out_enable=0 is illegal.
- Illegal access of any kind: no state change, bus_error=1 for exactly the next cycle, err_addr <= access address.
- read=1 and write=1 together: the write is performed if legal; the read is ignored and data_bus_in is held; bus_error pulses.
- I/O map:
  - +0x0 gpio_out, read/write.
  - +0x4 cycle_count, read-only; writes are silently ignored and are not an error.
  - +0x8 err_addr, read-only.
  - +0xC reads 0; writes are ignored.
- cycle_count increments every non-reset cycle and wraps from 0xFFFF_FFFF to 0. A read of it returns the value before the increment at that edge.
- Read-after-write to the same word on consecutive edges returns the new data; the RAM is write-first.

Decomposition:
- drisc_bus_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - I/O offsets IO_GPIO=0x0, IO_COUNT=0x4, IO_ERR=0x8;
  - a function returning the 4-bit byte enable from size and offset.
- One sub-module, drisc_byte_lane_decode: combinational. Inputs are size and offset; outputs are the byte enables and the alignment-legal flag. It is shared by the RAM and GPIO write paths.
- RAM is an inferred array in the top module.

Test Plan:
- Latch 0x100 with write_address; next cycle write a word 0xDEADBEEF; next cycle read -> data_bus_in=0xDEADBEEF one edge after the read, bus_error stays 0.
- Byte write of 0x0000AA00 at address 0x101 over a word of 0x11223344 -> reading 0x100 returns 0x1122AA44. Half write of 0x55660000 at 0x102 -> reading 0x100 returns 0x5566AA44.
- Half write at 0x103 and word read at 0x102 -> each gives a bus_error pulse with no RAM change; data_bus_in=0 after the read; reading IO_BASE+8 returns 0x102.
- Write 0x0000000F to IO_BASE+0 -> gpio_out=0x0000000F. Write to IO_BASE+4 -> no error. Two reads of IO_BASE+4 spaced 5 cycles apart differ by 5.
- Simultaneous read and write to 0x200 with data 0x12345678 -> RAM updated, data_bus_in unchanged, bus_error pulses. Also: write with data_bus_out_enable=0 -> error and no change.
- Hold reset low mid-write while gpio_out=0xFF -> gpio_out=0, cycle_count restarts at 0, bus_error=0, and the write is not committed.
